panel_ctrl: RTL and testbench

PANEL_CTRL -- requirements
Module: panel_ctrl

---
 rtl/panel_ctrl_pkg.sv | 32 +++
 rtl/panel_ctrl_if.sv | 24 ++
 rtl/panel_btn_arb.sv | 25 ++
 rtl/panel_ctrl.sv | 177 +++++++++++++++++
 tb/tb_panel_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/panel_ctrl_pkg.sv
// Shared types for the front-panel controller: FSM state encoding, button grant vector, widths.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package panel_ctrl_pkg;

    localparam int ADDR_W       = 8;
    localparam int DATA_W       = 16;
    localparam int STEP_TMO_DEF = 255;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOOK = 3'd1,
        LOAD = 3'd2,
        STEP = 3'd3,
        RUN  = 3'd4
    } panel_state_e;

    // One-hot result of button arbitration, highest priority first.
    typedef struct packed {
        logic setpc;
        logic load;
        logic look;
        logic step;
        logic run;
    } btn_grant_t;

    // Retire counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [DATA_W-1:0] sat_inc16(input logic [DATA_W-1:0] v);
        return (v == {DATA_W{1'b1}}) ? v : v + DATA_W'(1);
    endfunction

endpackage

// File: rtl/panel_ctrl_if.sv
// Panel-to-memory request bus: one outstanding request, held until accepted.
// Latency: wires only.
// Backpressure: master holds val/wen/addr/wdata until the cycle rdy is high.
interface panel_ctrl_if;
    import panel_ctrl_pkg::*;

    logic              mem_val;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rdy;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_val, mem_wen, mem_addr, mem_wdata,
        input  mem_rdy, mem_rdata
    );

    modport slave (
        input  mem_val, mem_wen, mem_addr, mem_wdata,
        output mem_rdy, mem_rdata
    );

endinterface

// File: rtl/panel_btn_arb.sv
// Fixed-priority resolver for simultaneous panel buttons: setpc > load > look > step > run.
// Latency: combinational, 0 cycles.
// Backpressure: none; losing buttons are dropped, not queued.
module panel_btn_arb
    import panel_ctrl_pkg::*;
(
    input  logic       setpc_i,
    input  logic       load_i,
    input  logic       look_i,
    input  logic       step_i,
    input  logic       run_i,
    output btn_grant_t grant_o
);

    // Grant exactly one button, the highest-priority one pressed.
    always_comb begin
        grant_o = '0;
        if (setpc_i)     grant_o.setpc = 1'b1;
        else if (load_i) grant_o.load  = 1'b1;
        else if (look_i) grant_o.look  = 1'b1;
        else if (step_i) grant_o.step  = 1'b1;
        else if (run_i)  grant_o.run   = 1'b1;
    end

endmodule

// File: rtl/panel_ctrl.sv
// Front-panel controller: examine/deposit memory, set PC, single-step and run the core.
// Latency: every output registered; a button acts on the cycle after its pulse.
// Backpressure: memory request held until mem_rdy; buttons ignored while a request is open.
module panel_ctrl
    import panel_ctrl_pkg::*;
#(
    parameter int STEP_TMO = STEP_TMO_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] sw_addr_i,
    input  logic [DATA_W-1:0] sw_data_i,
    input  logic              btn_load_i,
    input  logic              btn_look_i,
    input  logic              btn_step_i,
    input  logic              btn_run_i,
    input  logic              btn_stop_i,
    input  logic              btn_setpc_i,
    output logic              cpu_exec_o,
    output logic              pc_wen_o,
    output logic [ADDR_W-1:0] pc_o,
    input  logic              instr_val_i,
    input  logic              halt_i,
    input  logic [ADDR_W-1:0] core_pc_i,
    panel_ctrl_if.master      mem,
    output logic [ADDR_W-1:0] disp_addr_o,
    output logic [DATA_W-1:0] disp_data_o,
    output logic [2:0]        state_o,
    output logic              halted_o,
    output logic              err_o,
    output logic [DATA_W-1:0] retired_o
);

    // Watchdog is never narrower than 8 bits, wider if STEP_TMO needs it.
    localparam int WDOG_W = ($clog2(STEP_TMO + 1) > 8) ? $clog2(STEP_TMO + 1) : 8;

    panel_state_e      state_q;
    logic              cpu_exec_q;
    logic              pc_wen_q;
    logic [ADDR_W-1:0] pc_q;
    logic              mem_val_q;
    logic              mem_wen_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [ADDR_W-1:0] disp_addr_q;
    logic [DATA_W-1:0] disp_data_q;
    logic              halted_q;
    logic              err_q;
    logic [DATA_W-1:0] retired_q;
    logic [DATA_W-1:0] retired_d;
    logic [WDOG_W-1:0] wdog_q;
    logic [WDOG_W-1:0] wdog_d;
    logic              wdog_exp;
    btn_grant_t        grant;

    // Step/run are masked while halted so a refused press never counts as accepted
    // (and therefore never clears err).
    panel_btn_arb u_arb (
        .setpc_i (btn_setpc_i),
        .load_i  (btn_load_i),
        .look_i  (btn_look_i),
        .step_i  (btn_step_i & ~halted_q),
        .run_i   (btn_run_i  & ~halted_q),
        .grant_o (grant)
    );

    // Next values for the saturating retire counter and the step watchdog.
    always_comb begin
        retired_d = sat_inc16(retired_q);
        wdog_d    = wdog_q + WDOG_W'(1);
        wdog_exp  = (wdog_q == WDOG_W'(STEP_TMO - 1));
    end

    // Panel FSM with all outputs registered alongside the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cpu_exec_q  <= 1'b0;
            pc_wen_q    <= 1'b0;
            pc_q        <= '0;
            mem_val_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            disp_addr_q <= '0;
            disp_data_q <= '0;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
            retired_q   <= '0;
            wdog_q      <= '0;
        end else begin
            pc_wen_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Stop is not part of the grant, so it neither acts nor clears err here.
                    if (grant != '0) err_q <= 1'b0;
                    if (grant.setpc) begin
                        pc_wen_q  <= 1'b1;
                        pc_q      <= sw_addr_i;
                        halted_q  <= 1'b0;
                        retired_q <= '0;
                    end else if (grant.load) begin
                        mem_val_q   <= 1'b1;
                        mem_wen_q   <= 1'b1;
                        mem_addr_q  <= sw_addr_i;
                        mem_wdata_q <= sw_data_i;
                        state_q     <= LOAD;
                    end else if (grant.look) begin
                        mem_val_q  <= 1'b1;
                        mem_wen_q  <= 1'b0;
                        mem_addr_q <= sw_addr_i;
                        state_q    <= LOOK;
                    end else if (grant.step) begin
                        cpu_exec_q <= 1'b1;
                        wdog_q     <= '0;
                        state_q    <= STEP;
                    end else if (grant.run) begin
                        cpu_exec_q <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                LOOK, LOAD: begin
                    // Request stays frozen until accepted; every button is ignored meanwhile.
                    if (mem.mem_rdy) begin
                        mem_val_q   <= 1'b0;
                        mem_wen_q   <= 1'b0;
                        disp_data_q <= (state_q == LOOK) ? mem.mem_rdata : mem_wdata_q;
                        if (state_q == LOOK) disp_addr_q <= mem_addr_q;
                        state_q     <= IDLE;
                    end
                end
                STEP: begin
                    wdog_q <= wdog_d;
                    if (instr_val_i) retired_q <= retired_d;
                    if (halt_i)      halted_q  <= 1'b1;
                    // A retire in the last allowed cycle still counts as success.
                    if (wdog_exp && !instr_val_i && !halt_i) err_q <= 1'b1;
                    if (instr_val_i || halt_i || btn_stop_i || wdog_exp) begin
                        cpu_exec_q  <= 1'b0;
                        wdog_q      <= '0;
                        disp_addr_q <= core_pc_i;
                        state_q     <= IDLE;
                    end
                end
                RUN: begin
                    if (instr_val_i) retired_q <= retired_d;
                    if (halt_i)      halted_q  <= 1'b1;
                    if (halt_i || btn_stop_i) begin
                        cpu_exec_q  <= 1'b0;
                        disp_addr_q <= core_pc_i;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    cpu_exec_q <= 1'b0;
                    mem_val_q  <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign cpu_exec_o    = cpu_exec_q;
    assign pc_wen_o      = pc_wen_q;
    assign pc_o          = pc_q;
    assign mem.mem_val   = mem_val_q;
    assign mem.mem_wen   = mem_wen_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign disp_addr_o   = disp_addr_q;
    assign disp_data_o   = disp_data_q;
    assign state_o       = state_q;
    assign halted_o      = halted_q;
    assign err_o         = err_q;
    assign retired_o     = retired_q;

endmodule

// File: tb/tb_panel_ctrl.sv
// Self-checking bench for panel_ctrl: directed panel scenarios plus randomized
// memory and step traffic, checked against a behavioural model of the panel.
module tb_panel_ctrl;
    import panel_ctrl_pkg::*;

    localparam int TMO = 8;

    logic        clk_i  = 1'b0;
    logic        rst_ni = 1'b0;
    logic [7:0]  sw_addr;
    logic [15:0] sw_data;
    logic        b_load, b_look, b_step, b_run, b_stop, b_setpc;
    logic        cpu_exec, pc_wen;
    logic [7:0]  pc;
    logic        instr_val, halt;
    logic [7:0]  core_pc;
    logic [7:0]  disp_addr;
    logic [15:0] disp_data;
    logic [2:0]  state;
    logic        halted, err;
    logic [15:0] retired;

    panel_ctrl_if mem_if ();

    panel_ctrl #(.STEP_TMO(TMO)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .sw_addr_i   (sw_addr),
        .sw_data_i   (sw_data),
        .btn_load_i  (b_load),
        .btn_look_i  (b_look),
        .btn_step_i  (b_step),
        .btn_run_i   (b_run),
        .btn_stop_i  (b_stop),
        .btn_setpc_i (b_setpc),
        .cpu_exec_o  (cpu_exec),
        .pc_wen_o    (pc_wen),
        .pc_o        (pc),
        .instr_val_i (instr_val),
        .halt_i      (halt),
        .core_pc_i   (core_pc),
        .mem         (mem_if.master),
        .disp_addr_o (disp_addr),
        .disp_data_o (disp_data),
        .state_o     (state),
        .halted_o    (halted),
        .err_o       (err),
        .retired_o   (retired)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_bad = 0;

    // dev_mem is the memory device as the DUT modified it; ref_mem is what the
    // panel operator intended to be there.
    logic [15:0] dev_mem [256];
    logic [15:0] ref_mem [256];
    logic [15:0] exp_retired;
    logic [7:0]  exp_daddr;
    logic [15:0] exp_ddata;

    task automatic tick();
        @(negedge clk_i);
    endtask

    // v = {setpc, load, look, step, run, stop}, held for one cycle.
    task automatic press(input logic [5:0] v);
        {b_setpc, b_load, b_look, b_step, b_run, b_stop} = v;
        tick();
        {b_setpc, b_load, b_look, b_step, b_run, b_stop} = 6'b0;
    endtask

    // Memory responder: accepts the open request after lat cycles, optionally
    // pulsing buttons mid-request, and reports what it saw.
    task automatic mem_serve(input int lat, input logic [5:0] mid, output bit seen,
                             output logic [7:0] a, output logic [15:0] wd, output logic w,
                             output int held, output bit stable, output bit pcw);
        int c;
        seen = 0; held = 0; stable = 1; pcw = 0; a = 0; wd = 0; w = 0;
        for (int i = 0; i < 20 && mem_if.mem_val !== 1'b1; i++) tick();
        if (mem_if.mem_val !== 1'b1) return;
        seen = 1; a = mem_if.mem_addr; wd = mem_if.mem_wdata; w = mem_if.mem_wen;
        c = 0;
        while (mem_if.mem_val === 1'b1 && c < 40) begin
            if (mem_if.mem_addr !== a || mem_if.mem_wdata !== wd || mem_if.mem_wen !== w) stable = 0;
            if (pc_wen === 1'b1) pcw = 1;
            if (c == lat) begin mem_if.mem_rdy = 1'b1; mem_if.mem_rdata = dev_mem[a]; end
            if (c == 1) {b_setpc, b_load, b_look, b_step, b_run, b_stop} = mid;
            tick();
            mem_if.mem_rdy = 1'b0; mem_if.mem_rdata = 16'($urandom);
            {b_setpc, b_load, b_look, b_step, b_run, b_stop} = 6'b0;
            c++;
        end
        held = c;
        if (w === 1'b1) dev_mem[a] = wd;
    endtask

    // Presses step, fires instr_val (kind 0) or stop (kind 1) in STEP cycle fire_at,
    // kind 2 fires nothing; counts the cycles cpu_exec was seen high.
    task automatic run_step(input int fire_at, input int kind, output int exec_cycles,
                            output logic [7:0] cpc);
        exec_cycles = 0; cpc = 0;
        press(6'b000100);
        for (int k = 1; k <= 30; k++) begin
            if (cpu_exec !== 1'b1) break;
            exec_cycles++;
            core_pc = 8'($urandom); cpc = core_pc;
            if (k == fire_at && kind == 0) instr_val = 1'b1;
            if (k == fire_at && kind == 1) b_stop = 1'b1;
            tick();
            instr_val = 1'b0; b_stop = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick(); tick();
        n_vec++; if ({cpu_exec, pc_wen, mem_if.mem_val, halted, err} !== 5'b0) begin n_bad++; $display("FAIL reset_flags got=%b exp=00000", {cpu_exec, pc_wen, mem_if.mem_val, halted, err}); end
        n_vec++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state got=%0d exp=0", state); end
        n_vec++; if (retired !== 16'h0) begin n_bad++; $display("FAIL reset_retired got=%h exp=0", retired); end
        n_vec++; if ({disp_addr, disp_data, pc} !== 32'h0) begin n_bad++; $display("FAIL reset_regs got=%h exp=0", {disp_addr, disp_data, pc}); end
        rst_ni = 1'b1;
        tick();
        exp_retired = 0; exp_daddr = 0; exp_ddata = 0;
    endtask

    task automatic test_load_basic();
        bit seen, stable, pcw; logic [7:0] a; logic [15:0] wd; logic w; int held;
        sw_addr = 8'h20; sw_data = 16'h1234;
        press(6'b010000);
        n_vec++; if (state !== 3'd2) begin n_bad++; $display("FAIL load_state got=%0d exp=2", state); end
        mem_serve(3, 6'b0, seen, a, wd, w, held, stable, pcw);
        ref_mem[8'h20] = 16'h1234; exp_ddata = 16'h1234;
        n_vec++; if ({seen, w, a, wd} !== {1'b1, 1'b1, 8'h20, 16'h1234}) begin n_bad++; $display("FAIL load_req got=%b/%b/%h/%h exp=1/1/20/1234", seen, w, a, wd); end
        n_vec++; if (held !== 4 || stable !== 1'b1) begin n_bad++; $display("FAIL load_hold got=%0d/%0b exp=4/1", held, stable); end
        n_vec++; if (disp_data !== exp_ddata || disp_addr !== exp_daddr) begin n_bad++; $display("FAIL load_disp got=%h/%h exp=%h/%h", disp_addr, disp_data, exp_daddr, exp_ddata); end
        tick(); tick();
        n_vec++; if (mem_if.mem_val !== 1'b0 || state !== 3'd0) begin n_bad++; $display("FAIL load_done got=%b/%0d exp=0/0", mem_if.mem_val, state); end
    endtask

    task automatic test_look_stop();
        bit seen, stable, pcw; logic [7:0] a; logic [15:0] wd; logic w; int held;
        sw_addr = 8'h20; sw_data = 16'($urandom);
        press(6'b001000);
        n_vec++; if (state !== 3'd1) begin n_bad++; $display("FAIL look_state got=%0d exp=1", state); end
        mem_serve(3, 6'b000001, seen, a, wd, w, held, stable, pcw);
        exp_daddr = 8'h20; exp_ddata = ref_mem[8'h20];
        n_vec++; if ({seen, w, a} !== {1'b1, 1'b0, 8'h20}) begin n_bad++; $display("FAIL look_req got=%b/%b/%h exp=1/0/20", seen, w, a); end
        n_vec++; if (held !== 4 || stable !== 1'b1) begin n_bad++; $display("FAIL look_stop_hold got=%0d/%0b exp=4/1", held, stable); end
        n_vec++; if (disp_data !== exp_ddata || disp_addr !== exp_daddr) begin n_bad++; $display("FAIL look_disp got=%h/%h exp=%h/%h", disp_addr, disp_data, exp_daddr, exp_ddata); end
        n_vec++; if (state !== 3'd0) begin n_bad++; $display("FAIL look_idle got=%0d exp=0", state); end
    endtask

    task automatic test_step_basic();
        int ex; logic [7:0] cpc;
        sw_addr = 8'h10;
        press(6'b100000);
        n_vec++; if ({pc_wen, pc} !== {1'b1, 8'h10}) begin n_bad++; $display("FAIL setpc_strobe got=%b/%h exp=1/10", pc_wen, pc); end
        n_vec++; if (halted !== 1'b0 || retired !== 16'h0 || state !== 3'd0) begin n_bad++; $display("FAIL setpc_clear got=%b/%h/%0d exp=0/0/0", halted, retired, state); end
        tick();
        n_vec++; if (pc_wen !== 1'b0) begin n_bad++; $display("FAIL setpc_one_cycle got=%b exp=0", pc_wen); end
        exp_retired = 0;
        run_step(5, 0, ex, cpc);
        exp_retired = exp_retired + 1; exp_daddr = cpc;
        n_vec++; if (ex !== 5) begin n_bad++; $display("FAIL step_exec_cycles got=%0d exp=5", ex); end
        n_vec++; if (retired !== exp_retired || state !== 3'd0) begin n_bad++; $display("FAIL step_retire got=%h/%0d exp=%h/0", retired, state, exp_retired); end
        n_vec++; if (disp_addr !== exp_daddr) begin n_bad++; $display("FAIL step_disp_pc got=%h exp=%h", disp_addr, exp_daddr); end
    endtask

    task automatic test_random_step();
        int ex, kind, fire, exp_ex; logic [7:0] cpc; logic exp_err;
        for (int it = 0; it < 8; it++) begin
            kind = $urandom_range(0, 1);
            fire = (kind == 0) ? $urandom_range(1, 10) : $urandom_range(1, TMO - 1);
            run_step(fire, kind, ex, cpc);
            exp_err = 0;
            if (kind == 0 && fire <= TMO) begin exp_ex = fire; exp_retired = exp_retired + 1; end
            else if (kind == 0) begin exp_ex = TMO; exp_err = 1; end
            else exp_ex = fire;
            exp_daddr = cpc;
            n_vec++; if (ex !== exp_ex) begin n_bad++; $display("FAIL rstep_exec it=%0d got=%0d exp=%0d", it, ex, exp_ex); end
            n_vec++; if (retired !== exp_retired) begin n_bad++; $display("FAIL rstep_retired it=%0d got=%h exp=%h", it, retired, exp_retired); end
            n_vec++; if (err !== exp_err || state !== 3'd0) begin n_bad++; $display("FAIL rstep_err it=%0d got=%b/%0d exp=%b/0", it, err, state, exp_err); end
            n_vec++; if (disp_addr !== exp_daddr) begin n_bad++; $display("FAIL rstep_disp it=%0d got=%h exp=%h", it, disp_addr, exp_daddr); end
        end
    endtask

    task automatic test_run_stop();
        bit ok; int cnt, n; logic [7:0] cpc;
        press(6'b000010);
        ok = 1; cnt = 0; n = $urandom_range(3, 8);
        for (int c = 0; c < 60 && cnt < n; c++) begin
            if (cpu_exec !== 1'b1 || state !== 3'd4) ok = 0;
            instr_val = 1'($urandom_range(0, 1)); core_pc = 8'($urandom);
            if (instr_val) cnt++;
            tick();
            instr_val = 1'b0;
        end
        if (cpu_exec !== 1'b1) ok = 0;
        core_pc = 8'($urandom); cpc = core_pc;
        press(6'b000001);
        exp_retired = exp_retired + 16'(cnt); exp_daddr = cpc;
        n_vec++; if (ok !== 1'b1) begin n_bad++; $display("FAIL run_exec_held got=%b exp=1", ok); end
        n_vec++; if (cpu_exec !== 1'b0 || state !== 3'd0 || halted !== 1'b0) begin n_bad++; $display("FAIL run_stop_exit got=%b/%0d/%b exp=0/0/0", cpu_exec, state, halted); end
        n_vec++; if (retired !== exp_retired || disp_addr !== exp_daddr) begin n_bad++; $display("FAIL run_stop_regs got=%h/%h exp=%h/%h", retired, disp_addr, exp_retired, exp_daddr); end
    endtask

    task automatic test_run_halt();
        int cnt; logic [7:0] cpc;
        sw_addr = 8'($urandom);
        press(6'b100000);
        exp_retired = 0;
        press(6'b000010);
        cnt = 0;
        for (int c = 0; c < 80 && cnt < 10; c++) begin
            instr_val = 1'($urandom_range(0, 1)); core_pc = 8'($urandom);
            if (instr_val) cnt++;
            tick();
            instr_val = 1'b0;
        end
        exp_retired = 16'(cnt);
        core_pc = 8'($urandom); cpc = core_pc; halt = 1'b1;
        tick();
        halt = 1'b0; exp_daddr = cpc;
        n_vec++; if (cpu_exec !== 1'b0 || halted !== 1'b1 || state !== 3'd0) begin n_bad++; $display("FAIL halt_exit got=%b/%b/%0d exp=0/1/0", cpu_exec, halted, state); end
        n_vec++; if (retired !== 16'd10 || disp_addr !== exp_daddr) begin n_bad++; $display("FAIL halt_regs got=%h/%h exp=000a/%h", retired, disp_addr, exp_daddr); end
        press(6'b000010);
        n_vec++; if (cpu_exec !== 1'b0 || state !== 3'd0) begin n_bad++; $display("FAIL halted_run_ignored got=%b/%0d exp=0/0", cpu_exec, state); end
        press(6'b000100);
        n_vec++; if (cpu_exec !== 1'b0 || state !== 3'd0) begin n_bad++; $display("FAIL halted_step_ignored got=%b/%0d exp=0/0", cpu_exec, state); end
        press(6'b100000);
        exp_retired = 0;
        n_vec++; if (halted !== 1'b0 || retired !== 16'h0) begin n_bad++; $display("FAIL setpc_unhalt got=%b/%h exp=0/0", halted, retired); end
    endtask

    task automatic test_timeout();
        int ex; logic [7:0] cpc; bit seen, stable, pcw; logic [7:0] a; logic [15:0] wd; logic w; int held;
        run_step(0, 2, ex, cpc);
        exp_daddr = cpc;
        n_vec++; if (ex !== TMO) begin n_bad++; $display("FAIL tmo_exec got=%0d exp=%0d", ex, TMO); end
        n_vec++; if (err !== 1'b1 || state !== 3'd0 || retired !== exp_retired) begin n_bad++; $display("FAIL tmo_err got=%b/%0d/%h exp=1/0/%h", err, state, retired, exp_retired); end
        press(6'b000001);
        n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL stop_keeps_err got=%b exp=1", err); end
        sw_addr = 8'h20;
        press(6'b001000);
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL look_clears_err got=%b exp=0", err); end
        mem_serve($urandom_range(0, 3), 6'b0, seen, a, wd, w, held, stable, pcw);
        exp_daddr = 8'h20; exp_ddata = ref_mem[8'h20];
        n_vec++; if (disp_data !== exp_ddata) begin n_bad++; $display("FAIL tmo_look_data got=%h exp=%h", disp_data, exp_ddata); end
    endtask

    task automatic test_load_run();
        bit seen, stable, pcw; logic [7:0] a; logic [15:0] wd; logic w; int held;
        sw_addr = 8'h33; sw_data = 16'($urandom);
        press(6'b010010);
        n_vec++; if (state !== 3'd2 || cpu_exec !== 1'b0) begin n_bad++; $display("FAIL load_run_prio got=%0d/%b exp=2/0", state, cpu_exec); end
        mem_serve(1, 6'b0, seen, a, wd, w, held, stable, pcw);
        ref_mem[8'h33] = sw_data; exp_ddata = sw_data;
        n_vec++; if ({seen, w, a, wd} !== {1'b1, 1'b1, 8'h33, sw_data}) begin n_bad++; $display("FAIL load_run_req got=%b/%b/%h/%h exp=1/1/33/%h", seen, w, a, wd, sw_data); end
        tick(); tick();
        n_vec++; if (state !== 3'd0 || cpu_exec !== 1'b0 || disp_data !== exp_ddata) begin n_bad++; $display("FAIL load_run_dropped got=%0d/%b/%h exp=0/0/%h", state, cpu_exec, disp_data, exp_ddata); end
    endtask

    task automatic test_random_mem();
        bit seen, stable, pcw, is_load; logic [7:0] a, addr; logic [15:0] wd, data; logic w; int held, lat;
        for (int it = 0; it < 12; it++) begin
            is_load = 1'($urandom_range(0, 1));
            addr = 8'h40 + 8'($urandom_range(0, 3)); data = 16'($urandom); lat = $urandom_range(0, 4);
            sw_addr = addr; sw_data = data;
            press({1'b0, is_load, 1'b1, 3'($urandom)});
            mem_serve(lat, {3'b100, 3'($urandom)}, seen, a, wd, w, held, stable, pcw);
            if (is_load) begin ref_mem[addr] = data; exp_ddata = data; end
            else begin exp_ddata = ref_mem[addr]; exp_daddr = addr; end
            n_vec++; if ({seen, w, a} !== {1'b1, is_load, addr} || (is_load && wd !== data)) begin n_bad++; $display("FAIL rmem_req it=%0d got=%b/%b/%h/%h exp=1/%b/%h/%h", it, seen, w, a, wd, is_load, addr, data); end
            n_vec++; if (held !== lat + 1 || stable !== 1'b1 || pcw !== 1'b0) begin n_bad++; $display("FAIL rmem_hold it=%0d got=%0d/%b/%b exp=%0d/1/0", it, held, stable, pcw, lat + 1); end
            n_vec++; if (disp_data !== exp_ddata || disp_addr !== exp_daddr || state !== 3'd0) begin n_bad++; $display("FAIL rmem_disp it=%0d got=%h/%h/%0d exp=%h/%h/0", it, disp_addr, disp_data, state, exp_daddr, exp_ddata); end
        end
    endtask

    task automatic test_async_reset();
        sw_addr = 8'($urandom);
        press(6'b001000);
        n_vec++; if (mem_if.mem_val !== 1'b1) begin n_bad++; $display("FAIL arst_pre_val got=%b exp=1", mem_if.mem_val); end
        #2 rst_ni = 1'b0;
        #1;
        n_vec++; if (mem_if.mem_val !== 1'b0 || state !== 3'd0) begin n_bad++; $display("FAIL arst_drop got=%b/%0d exp=0/0", mem_if.mem_val, state); end
        n_vec++; if ({disp_addr, disp_data, retired} !== 40'h0) begin n_bad++; $display("FAIL arst_regs got=%h exp=0", {disp_addr, disp_data, retired}); end
        tick();
        rst_ni = 1'b1;
        tick(); tick();
        n_vec++; if (mem_if.mem_val !== 1'b0 || state !== 3'd0) begin n_bad++; $display("FAIL arst_after got=%b/%0d exp=0/0", mem_if.mem_val, state); end
    endtask

    initial begin
        sw_addr = 0; sw_data = 0;
        {b_setpc, b_load, b_look, b_step, b_run, b_stop} = 6'b0;
        instr_val = 0; halt = 0; core_pc = 0;
        mem_if.mem_rdy = 0; mem_if.mem_rdata = 0;
        for (int i = 0; i < 256; i++) begin dev_mem[i] = 16'($urandom); ref_mem[i] = dev_mem[i]; end
        test_reset();
        test_load_basic();
        test_look_stop();
        test_step_basic();
        test_random_step();
        test_run_stop();
        test_run_halt();
        test_timeout();
        test_load_run();
        test_random_mem();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
